// File: rtl/rv32i_pkg.sv
// Shared RV32I control encodings for the PC redirect path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: branch/jump/pc_src encodings, BHT reset value, flush FSM states,
// and the 2-bit saturating counter update used by the BHT.
package rv32i_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_RSVD = 3'd7
    } branch_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_JAL  = 2'd1,
        JMP_JALR = 2'd2,
        JMP_RSVD = 2'd3
    } jump_e;

    typedef enum logic [1:0] {
        PC_SRC_NONE   = 2'd0,
        PC_SRC_TARGET = 2'd1,
        PC_SRC_JALR   = 2'd2,
        PC_SRC_SEQ    = 2'd3
    } pc_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } flush_st_e;

    // Weakly not-taken.
    localparam logic [1:0] BHT_RST = 2'b01;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters indexed by PC[IDX_W+1:2].
// Latency: read is combinational; write lands on the rising edge (no read bypass).
// Backpressure: none; one read and one write accepted every cycle.
//
// Ports: clk_i, rst_n_i (sync, active-low); rd_pc_i -> rd_ctr_o;
//        wr_en_i, wr_pc_i, wr_taken_i (saturating update of entry at wr_pc_i).
module bht_2bit
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic [1:0]      rd_ctr_o,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic            wr_taken_i
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]       ctr [DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    // Word-aligned instructions: the two low PC bits carry no information.
    assign rd_idx = rd_pc_i[IDX_W+1:2];
    assign wr_idx = wr_pc_i[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc_i[XLEN-1:IDX_W+2], rd_pc_i[1:0],
                              wr_pc_i[XLEN-1:IDX_W+2], wr_pc_i[1:0]};

    assign rd_ctr_o = ctr[rd_idx];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= BHT_RST;
            end
        end else if (wr_en_i) begin
            ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken_i);
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Resolves RV32I branches/jumps in EX, drives the PC mux select and flush, predicts in IF.
// Latency: pc_src_o/flush_o/pred_taken_o combinational; BHT, counters, hold state next edge.
// Backpressure: none; during the flush window EX contents are treated as wrong-path and ignored.
//
// Ports: clk_i, rst_n_i (sync, active-low); if_valid_i, if_pc_i -> pred_taken_o;
//        ex_* and ALU flags -> pc_src_o, flush_o; branch_cnt_o, mispred_cnt_o perf counters.
module pc_redirect_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_DEPTH    = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             if_valid_i,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             pred_taken_o,
    input  logic             ex_valid_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [2:0]       ex_branch_i,
    input  logic [1:0]       ex_jump_i,
    input  logic             ex_pred_taken_i,
    input  logic             flg_zero_i,
    input  logic             flg_neg_i,
    input  logic             flg_ovf_i,
    input  logic             flg_carry_i,
    output logic [1:0]       pc_src_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);
    localparam int HCW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(FLUSH_CYCLES - 1);

    flush_st_e      state;
    logic [HCW-1:0] hold_cnt;

    logic       eq, lt, ltu;
    logic       is_branch, is_jump, cond_taken;
    logic       live, redirect, bht_we, mispred;
    logic [1:0] pc_src;
    logic [1:0] if_ctr;

    assign eq  = flg_zero_i;
    assign lt  = flg_neg_i ^ flg_ovf_i;
    assign ltu = !flg_carry_i;

    always_comb begin
        is_branch  = 1'b0;
        cond_taken = 1'b0;
        case (ex_branch_i)
            BR_BEQ:  begin is_branch = 1'b1; cond_taken = eq;   end
            BR_BNE:  begin is_branch = 1'b1; cond_taken = !eq;  end
            BR_BLT:  begin is_branch = 1'b1; cond_taken = lt;   end
            BR_BGE:  begin is_branch = 1'b1; cond_taken = !lt;  end
            BR_BLTU: begin is_branch = 1'b1; cond_taken = ltu;  end
            BR_BGEU: begin is_branch = 1'b1; cond_taken = !ltu; end
            default: ;
        endcase
    end

    assign is_jump = (ex_jump_i == JMP_JAL) || (ex_jump_i == JMP_JALR);
    // Reset gates everything so outputs are quiet while rst_n_i is low.
    assign live    = rst_n_i && ex_valid_i && (state == ST_IDLE);

    always_comb begin
        redirect = 1'b0;
        bht_we   = 1'b0;
        mispred  = 1'b0;
        pc_src   = PC_SRC_NONE;
        if (live) begin
            if (is_jump) begin
                // Jumps win over any branch code on the same instruction.
                redirect = 1'b1;
                pc_src   = ex_jump_i;
            end else if (is_branch) begin
                bht_we  = 1'b1;
                mispred = (cond_taken != ex_pred_taken_i);
                if (mispred) begin
                    redirect = 1'b1;
                    pc_src   = cond_taken ? PC_SRC_TARGET : PC_SRC_SEQ;
                end
            end
        end
    end

    assign pc_src_o     = pc_src;
    assign flush_o      = rst_n_i && (redirect || (state == ST_HOLD));
    assign pred_taken_o = rst_n_i && if_valid_i && if_ctr[1];

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .XLEN  (XLEN)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rd_pc_i    (if_pc_i),
        .rd_ctr_o   (if_ctr),
        .wr_en_i    (bht_we),
        .wr_pc_i    (ex_pc_i),
        .wr_taken_i (cond_taken)
    );

    // HOLD is occupied exactly while hold_cnt is non-zero.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect && FLUSH_CYCLES > 1) begin
                        hold_cnt <= HOLD_LOAD;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == HCW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            endcase
            if (bht_we) begin
                branch_cnt_o <= branch_cnt_o + 1'b1;
                if (mispred) begin
                    mispred_cnt_o <= mispred_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule
